// File: rtl/dmem_arb_pkg.sv
// Shared encodings for the data-memory arbiter: FSM/owner codes and
// requester indices.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_OWN0 = 2'b01,
        ST_OWN1 = 2'b10
    } arb_state_e;

    localparam logic       OWNER_P0     = 1'b0;
    localparam logic       OWNER_P1     = 1'b1;
    localparam logic [3:0] BYTE_EN_NONE = 4'b0000;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker: chooses the next owner from the live requests,
// breaking ties against the requester that owned the memory last.
module rr_pick2
    import dmem_arb_pkg::*;
(
    input  logic       req0,
    input  logic       req1,
    input  logic       last_owner,
    output arb_state_e next_state
);

    always_comb begin
        next_state = ST_IDLE;
        if (req0 && req1) begin
            next_state = (last_owner == OWNER_P1) ? ST_OWN0 : ST_OWN1;
        end else if (req0) begin
            next_state = ST_OWN0;
        end else if (req1) begin
            next_state = ST_OWN1;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares a single-port data memory between the CPU (port 0) and a secondary
// master (port 1) with round-robin fairness and bounded bursts.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int MAX_BURST = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    input  logic [3:0]    we0,
    output logic          gnt0,
    output logic [DW-1:0] rdata0,
    input  logic          req1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    input  logic [3:0]    we1,
    output logic          gnt1,
    output logic [DW-1:0] rdata1,
    output logic [AW-1:0] daddr,
    output logic [DW-1:0] dwdata,
    output logic [3:0]    dwe,
    input  logic [DW-1:0] drdata,
    output logic [1:0]    owner
);

    localparam int               CNT_W   = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST - 1);

    arb_state_e       state_q, state_d, pick_state;
    logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
    logic             last_owner_q, last_owner_d;
    logic             own_req, oth_req, yield;
    logic             pick_req0, pick_req1;

    rr_pick2 u_pick (
        .req0       (pick_req0),
        .req1       (pick_req1),
        .last_owner (last_owner_q),
        .next_state (pick_state)
    );

    always_comb begin
        own_req = 1'b0;
        oth_req = 1'b0;
        case (state_q)
            ST_OWN0: begin own_req = req0; oth_req = req1; end
            ST_OWN1: begin own_req = req1; oth_req = req0; end
            default: ;
        endcase

        // A yielding owner is masked out of the pick, so the picker either
        // hands off to the other port or falls back to IDLE.
        yield     = !own_req || (oth_req && (burst_cnt_q == CNT_MAX));
        pick_req0 = req0 && !((state_q == ST_OWN0) && yield);
        pick_req1 = req1 && !((state_q == ST_OWN1) && yield);

        state_d      = state_q;
        burst_cnt_d  = burst_cnt_q;
        last_owner_d = last_owner_q;
        if ((state_q == ST_IDLE) || yield) begin
            state_d = pick_state;
        end

        if (state_d != state_q) begin
            burst_cnt_d = '0;
            if (state_d == ST_OWN0) begin
                last_owner_d = OWNER_P0;
            end else if (state_d == ST_OWN1) begin
                last_owner_d = OWNER_P1;
            end
        end else if ((state_q != ST_IDLE) && (burst_cnt_q != CNT_MAX)) begin
            burst_cnt_d = burst_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            burst_cnt_q  <= '0;
            last_owner_q <= OWNER_P1;
        end else begin
            state_q      <= state_d;
            burst_cnt_q  <= burst_cnt_d;
            last_owner_q <= last_owner_d;
        end
    end

    always_comb begin
        daddr  = '0;
        dwdata = '0;
        dwe    = BYTE_EN_NONE;
        case (state_q)
            ST_OWN0: begin
                daddr  = addr0;
                dwdata = wdata0;
                dwe    = we0 & {4{req0}};
            end
            ST_OWN1: begin
                daddr  = addr1;
                dwdata = wdata1;
                dwe    = we1 & {4{req1}};
            end
            default: ;
        endcase
    end

    assign gnt0   = (state_q == ST_OWN0);
    assign gnt1   = (state_q == ST_OWN1);
    assign owner  = state_q;
    assign rdata0 = gnt0 ? drdata : '0;
    assign rdata1 = gnt1 ? drdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus random traffic, checked
// every cycle against a tenure-counting reference model and a shadow memory.
`timescale 1ns/1ps
module tb_dmem_arbiter;

    localparam int MB = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0, req1, gnt0, gnt1;
    logic [31:0] addr0, addr1, wdata0, wdata1, rdata0, rdata1;
    logic [3:0]  we0, we1, dwe;
    logic [31:0] daddr, dwdata, drdata;
    logic [1:0]  owner;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] mem     [16];
    logic [31:0] ref_mem [16];

    int m_owner = 0;
    int m_beats = 0;
    int m_last  = 2;

    logic [31:0] rd, rd_other, old_word;
    logic        b0, b1;
    int          n;

    dmem_arbiter #(.AW(32), .DW(32), .MAX_BURST(MB)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .addr0(addr0), .wdata0(wdata0), .we0(we0), .gnt0(gnt0), .rdata0(rdata0),
        .req1(req1), .addr1(addr1), .wdata1(wdata1), .we1(we1), .gnt1(gnt1), .rdata1(rdata1),
        .daddr(daddr), .dwdata(dwdata), .dwe(dwe), .drdata(drdata), .owner(owner)
    );

    always #5 clk = ~clk;

    assign drdata = mem[daddr[5:2]];

    always @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (dwe[b]) mem[daddr[5:2]][8*b +: 8] <= dwdata[8*b +: 8];
        end
    end

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] be);
        logic [31:0] r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    // Next owner from the arbitration rules: 0 = none, 1 = port0, 2 = port1.
    function automatic int model_next(input int own, input int beats, input int last,
                                      input logic r0, input logic r1);
        logic rx, ro;
        if (own == 0) begin
            if (r0 && r1) return (last == 1) ? 2 : 1;
            if (r0) return 1;
            if (r1) return 2;
            return 0;
        end
        rx = (own == 1) ? r0 : r1;
        ro = (own == 1) ? r1 : r0;
        if (!rx) return ro ? 3 - own : 0;
        if (ro && (beats + 1 >= MB)) return 3 - own;
        return own;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_owner <= 0;
            m_beats <= 0;
            m_last  <= 2;
        end else begin
            if (m_owner == 1 && req0)
                ref_mem[addr0[5:2]] <= merge(ref_mem[addr0[5:2]], wdata0, we0);
            if (m_owner == 2 && req1)
                ref_mem[addr1[5:2]] <= merge(ref_mem[addr1[5:2]], wdata1, we1);
            if (model_next(m_owner, m_beats, m_last, req0, req1) != m_owner) begin
                m_owner <= model_next(m_owner, m_beats, m_last, req0, req1);
                m_beats <= 0;
                if (model_next(m_owner, m_beats, m_last, req0, req1) != 0)
                    m_last <= model_next(m_owner, m_beats, m_last, req0, req1);
            end else if (m_owner != 0) begin
                m_beats <= m_beats + 1;
            end
        end
    end

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_cycle();
        logic [31:0] ea, ed, er0, er1;
        logic [3:0]  ewe;
        logic [1:0]  eown;
        ea = 0; ed = 0; ewe = 0; er0 = 0; er1 = 0; eown = 2'b00;
        if (m_owner == 1) begin
            eown = 2'b01; ea = addr0; ed = wdata0; ewe = req0 ? we0 : 4'b0;
            er0 = ref_mem[addr0[5:2]];
        end else if (m_owner == 2) begin
            eown = 2'b10; ea = addr1; ed = wdata1; ewe = req1 ? we1 : 4'b0;
            er1 = ref_mem[addr1[5:2]];
        end
        check("cycle", {gnt0, gnt1, owner, dwe, daddr, dwdata, rdata0, rdata1},
              {eown == 2'b01, eown == 2'b10, eown, ewe, ea, ed, er0, er1});
        check("no_overlap", {255'b0, gnt0 && gnt1}, 256'b0);
    endtask

    always @(negedge clk) compare_cycle();

    task automatic do_beat(input int p, input logic [31:0] a, input logic [3:0] be,
                           input logic [31:0] d, output logic [31:0] rdv);
        int k = 0;
        rdv = 0;
        if (p == 0) begin req0 = 1; addr0 = a; we0 = be; wdata0 = d; end
        else        begin req1 = 1; addr1 = a; we1 = be; wdata1 = d; end
        forever begin
            @(negedge clk);
            if ((p == 0) ? gnt0 : gnt1) break;
            k++;
            if (k > 20) begin
                check("beat_timeout", 256'd0, 256'd1);
                break;
            end
        end
        rdv      = (p == 0) ? rdata0 : rdata1;
        rd_other = (p == 0) ? rdata1 : rdata0;
        @(posedge clk); #1;
        if (p == 0) begin req0 = 0; we0 = 0; end
        else        begin req1 = 0; we1 = 0; end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 16; i++) begin
            mem[i]     <= 32'h1000_0000 + i;
            ref_mem[i] <= 32'h1000_0000 + i;
        end
        mem[8]     <= 32'h1122_3344;
        ref_mem[8] <= 32'h1122_3344;
        reset = 0;
        req0 = 1; addr0 = 0; wdata0 = 32'h0BAD_F00D; we0 = 4'hF;
        req1 = 1; addr1 = 0; wdata1 = 0;             we1 = 4'h0;

        // Reset held with both requesting: no grants, no writes.
        repeat (3) begin
            @(negedge clk);
            check("rst_gnt", {gnt0, gnt1}, 2'b00);
            check("rst_dwe", dwe, 4'h0);
        end
        @(posedge clk); #1 reset = 1;
        @(posedge clk); @(posedge clk); #1;
        check("rel_gnt0", gnt0, 1'b1);
        req0 = 0; req1 = 0; we0 = 0;
        repeat (3) @(posedge clk);
        #1;

        do_beat(0, 32'h10, 4'hF, 32'hDEAD_BEEF, rd);
        check("cpu_wr_mem", mem[4], 32'hDEAD_BEEF);
        do_beat(0, 32'h10, 4'h0, 32'h0, rd);
        check("cpu_rd", rd, 32'hDEAD_BEEF);
        check("cpu_rd_other", rd_other, 32'h0);
        repeat (3) @(posedge clk);
        #1;

        do_beat(1, 32'h20, 4'b0010, 32'h0000_AB00, rd);
        check("be_mem", mem[8], 32'h1122_AB44);
        do_beat(1, 32'h20, 4'h0, 32'h0, rd);
        check("be_rd", rd, 32'h1122_AB44);
        repeat (3) @(posedge clk);
        #1;

        // Contention: port1 owned last, so port0 starts; bursts of MB alternate.
        req0 = 1; addr0 = 32'h04; we0 = 0;
        req1 = 1; addr1 = 32'h08; we1 = 0;
        @(posedge clk);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check($sformatf("cont_owner_%0d", i), owner, ((i / MB) % 2 == 0) ? 2'b01 : 2'b10);
        end
        @(posedge clk); #1;
        req0 = 0; req1 = 0;
        repeat (3) @(posedge clk);
        #1;

        // Early release by port1 while port0 waits.
        req1 = 1; addr1 = 32'h30; we1 = 4'hF; wdata1 = 32'h55AA_55AA;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!gnt1 && n < 20);
        check("er_first_gnt1", gnt1, 1'b1);
        @(posedge clk); #1;
        req0 = 1; addr0 = 32'h30; we0 = 0;
        @(negedge clk);
        check("er_beat2", {gnt0, gnt1}, 2'b01);
        @(posedge clk); #1;
        req1 = 0;
        @(negedge clk);
        check("er_dead", {gnt0, gnt1, dwe}, {2'b01, 4'h0});
        @(posedge clk); #1;
        req1 = 1; we1 = 0;
        @(negedge clk);
        check("er_gnt0", gnt0, 1'b1);
        n = 1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (!gnt0) break;
            n++;
        end
        check("er_burst_len", n, MB);
        check("er_then_gnt1", gnt1, 1'b1);
        check("er_mem", mem[12], 32'h55AA_55AA);
        @(posedge clk); #1;
        req0 = 0; req1 = 0;
        repeat (3) @(posedge clk);
        #1;

        // Asynchronous reset in the middle of a port1 write tenure.
        req1 = 1; addr1 = 32'h34; we1 = 4'hF; wdata1 = 32'hCAFE_F00D;
        old_word = mem[13];
        @(posedge clk); #2;
        check("ar_pre", {gnt1, dwe}, {1'b1, 4'hF});
        #1 reset = 0;
        #1;
        check("ar_drop", {gnt1, dwe}, {1'b0, 4'h0});
        @(posedge clk); #1;
        check("ar_mem", mem[13], old_word);
        req1 = 0; we1 = 0;
        reset = 1;
        repeat (2) @(posedge clk);
        #1;

        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            b0 = gnt0 && req0;
            b1 = gnt1 && req1;
            @(posedge clk); #1;
            if (req0 && !b0) begin
                if ($urandom_range(0, 15) == 0) req0 = 0;
            end else begin
                req0   = ($urandom_range(0, 99) < 55);
                addr0  = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
                we0    = $urandom_range(0, 1) ? 4'($urandom) : 4'h0;
                wdata0 = $urandom;
            end
            if (req1 && !b1) begin
                if ($urandom_range(0, 15) == 0) req1 = 0;
            end else begin
                req1   = ($urandom_range(0, 99) < 55);
                addr1  = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
                we1    = $urandom_range(0, 1) ? 4'($urandom) : 4'h0;
                wdata1 = $urandom;
            end
        end
        req0 = 0; req1 = 0;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 16; i++) check($sformatf("final_mem_%0d", i), mem[i], ref_mem[i]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
